// File: rtl/mul_unit_iterative.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One 128-bit ripple adder is time-shared between partial-product
// accumulation (CALC) and the final two's-complement negation (NEGATE).

// 128-bit ripple-carry adder: sum = a + (b ^ {W{invert_b}}) + c_in.
// The carry out of the top bit is never needed, so it is not produced.
module full_adder_128bit #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         invert_b,
    input  logic         c_in,
    output logic [W-1:0] sum
);
    logic [W-1:0] carry;
    logic [W-1:0] b_eff;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign b_eff[gi] = b[gi] ^ invert_b;
            assign sum[gi]   = a[gi] ^ b_eff[gi] ^ carry[gi];
            if (gi < W - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
            end
        end
    endgenerate
endmodule

module mul_unit_iterative #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [1:0]        op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              flush,
    output logic              busy,
    output logic              result_valid,
    output logic [XLEN-1:0]   result,
    output logic [2*XLEN-1:0] product
);
    localparam int PW = 2 * XLEN;
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_NEGATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]     count_q, count_d;
    logic              neg_q, neg_d;
    logic              is_mul_q, is_mul_d;
    logic [PW-1:0]     product_q, product_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [PW-1:0]     adder_a;
    logic [PW-1:0]     adder_b;
    logic              adder_inv;
    logic              adder_cin;
    logic [PW-1:0]     adder_sum;

    logic              accept;
    logic              rs1_signed;
    logic              rs2_signed;
    logic [XLEN-1:0]   rs1_abs;
    logic [XLEN-1:0]   rs2_abs;
    logic [PW-1:0]     final_acc;

    full_adder_128bit #(.W(PW)) u_adder (
        .a        (adder_a),
        .b        (adder_b),
        .invert_b (adder_inv),
        .c_in     (adder_cin),
        .sum      (adder_sum)
    );

    assign start_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy         = (state_q == S_CALC) || (state_q == S_NEGATE);
    // A flush in the DONE cycle also hides that cycle's pulse.
    assign result_valid = (state_q == S_DONE) && !flush;
    assign result       = result_q;
    assign product      = product_q;

    assign accept     = start_valid && start_ready && !flush;
    assign rs1_signed = (op == OP_MULH) || (op == OP_MULHSU);
    assign rs2_signed = (op == OP_MULH);
    // Magnitudes; -2^(XLEN-1) maps to 2^(XLEN-1), which fits unsigned.
    assign rs1_abs    = (rs1_signed && rs1[XLEN-1]) ? (~rs1 + 1'b1) : rs1;
    assign rs2_abs    = (rs2_signed && rs2[XLEN-1]) ? (~rs2 + 1'b1) : rs2;

    // Next-state, datapath sequencing and adder input selection.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        neg_d     = neg_q;
        is_mul_d  = is_mul_q;
        product_d = product_q;
        result_d  = result_q;
        adder_a   = '0;
        adder_b   = '0;
        adder_inv = 1'b0;
        adder_cin = 1'b0;
        final_acc = acc_q;

        case (state_q)
            S_CALC: begin
                adder_a = acc_q;
                adder_b = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = adder_sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = S_NEGATE;
                end
            end
            S_NEGATE: begin
                // 0 + ~acc + 1 is -acc.
                adder_b   = acc_q;
                adder_inv = 1'b1;
                adder_cin = 1'b1;
                final_acc = neg_q ? adder_sum : acc_q;
                acc_d     = final_acc;
                product_d = final_acc;
                result_d  = is_mul_q ? final_acc[XLEN-1:0] : final_acc[PW-1:XLEN];
                state_d   = S_DONE;
            end
            default: begin
                // IDLE and DONE both accept a new operation.
                if (accept) begin
                    mcand_d  = {{XLEN{1'b0}}, rs1_abs};
                    mplier_d = rs2_abs;
                    neg_d    = (rs1_signed && rs1[XLEN-1]) ^ (rs2_signed && rs2[XLEN-1]);
                    is_mul_d = (op == OP_MUL);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_CALC;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Abort: back to IDLE with the last published result kept.
        if (flush) begin
            state_d   = S_IDLE;
            product_d = product_q;
            result_d  = result_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            is_mul_q  <= 1'b0;
            product_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            is_mul_q  <= is_mul_d;
            product_q <= product_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_mul_unit_iterative.sv
// Testbench for mul_unit_iterative: directed vectors, flush/reset
// sequences and randomized back-to-back operations against a model.
module tb_mul_unit_iterative;
    localparam int LATENCY = 66;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [1:0]   op;
    logic [63:0]  rs1;
    logic [63:0]  rs2;
    logic         flush;
    logic         busy;
    logic         result_valid;
    logic [63:0]  result;
    logic [127:0] product;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [1:0]   op;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] prod;
        logic [63:0]  res;
        string        name;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    mul_unit_iterative dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .rs1          (rs1),
        .rs2          (rs2),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .product      (product)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Mathematical product: sign- or zero-extend each operand to 128 bits
    // and multiply modulo 2^128.
    function automatic logic [127:0] model_prod(input logic [1:0] o, input logic [63:0] a,
                                                input logic [63:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = (o == 2'b01 || o == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = (o == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] model_res(input logic [1:0] o, input logic [127:0] p);
        return (o == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    // Issue one op from the current cycle and wait for its result pulse.
    task automatic do_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [127:0] ep, input logic [63:0] er, input string nm);
        int cyc;
        check({nm, " start_ready"}, 128'(start_ready), 128'(1));
        op = o;
        rs1 = a;
        rs2 = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        // Scribble on the operands: only the accepted values may matter.
        op  = 2'($urandom);
        rs1 = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        check({nm, " busy"}, 128'(busy), 128'(1));
        cyc = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                cyc = n + 1;
                break;
            end
        end
        check({nm, " latency"}, 128'(cyc), 128'(LATENCY));
        check({nm, " product"}, product, ep);
        check({nm, " result"}, 128'(result), 128'(er));
        $display("[TB] %s op=%0d rs1=0x%016h rs2=0x%016h product=0x%032h result=0x%016h cyc=%0d",
                 nm, o, a, b, product, result, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] p;
        logic [1:0]   o;
        logic [63:0]  a;
        logic [63:0]  b;
        int           pulses;

        vecs[0] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_max"};
        vecs[1] = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000, 64'h4000_0000_0000_0000, "mulh_min"};
        vecs[2] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1x2"};
        vecs[3] = '{2'b00, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
                    128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1, "mul_3xm5"};

        reset = 1'b1;
        start_valid = 1'b1;   // must be ignored while reset is high
        op = 2'b11;
        rs1 = 64'd5;
        rs2 = 64'd5;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 128'(busy), 128'(0));
        check("reset valid", 128'(result_valid), 128'(0));
        check("reset product", product, 128'(0));
        check("reset result", 128'(result), 128'(0));
        start_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset start_ready", 128'(start_ready), 128'(1));
        check("post-reset busy", 128'(busy), 128'(0));

        // Directed vectors, each followed by a check that the pulse is one cycle.
        for (int i = 0; i < 4; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].res, vecs[i].name);
            @(posedge clk);
            #1;
            check({vecs[i].name, " pulse end"}, 128'(result_valid), 128'(0));
            check({vecs[i].name, " held result"}, 128'(result), 128'(vecs[i].res));
        end

        // Flush in cycle 10 of a MULH.
        op = 2'b01;
        rs1 = 64'h1234_5678_9ABC_DEF0;
        rs2 = 64'h8000_0000_0000_0003;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        pulses = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        flush = 1'b1;
        start_valid = 1'b1;   // flush must win over a simultaneous request
        @(posedge clk);
        #1;
        flush = 1'b0;
        start_valid = 1'b0;
        check("flush no valid", 128'(pulses + int'(result_valid)), 128'(0));
        check("flush start_ready", 128'(start_ready), 128'(1));
        check("flush busy", 128'(busy), 128'(0));
        check("flush result kept", 128'(result), 128'(vecs[3].res));
        check("flush product kept", product, vecs[3].prod);
        $display("[TB] flush at cycle 10: result=0x%016h busy=%0d", result, busy);
        do_op(2'b11, 64'd7, 64'd6, 128'd42, 64'd0, "mulhu_7x6_after_flush");
        @(posedge clk);
        #1;

        // Reset at cycle 30 of CALC.
        op = 2'b11;
        rs1 = 64'hDEAD_BEEF_0000_0001;
        rs2 = 64'h0000_0001_CAFE_F00D;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset product", product, 128'(0));
        check("midreset result", 128'(result), 128'(0));
        check("midreset valid", 128'(result_valid), 128'(0));
        check("midreset busy", 128'(busy), 128'(0));
        pulses = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        check("midreset no pulse", 128'(pulses), 128'(0));
        $display("[TB] reset at cycle 30: product=0x%032h pulses=%0d", product, pulses);
        p = model_prod(2'b01, 64'hFFFF_FFFF_FFFF_FFF9, 64'd9);
        do_op(2'b01, 64'hFFFF_FFFF_FFFF_FFF9, 64'd9, p, model_res(2'b01, p), "mulh_after_reset");

        // Randomized ops issued back-to-back in each DONE cycle.
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: a = 64'h8000_0000_0000_0000;
                1: b = 64'hFFFF_FFFF_FFFF_FFFF;
                2: a = 64'd0;
                3: b = 64'd1;
                default: ;
            endcase
            p = model_prod(o, a, b);
            do_op(o, a, b, p, model_res(o, p), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
